spi_slave_burst: RTL

- Parametrised SPI slave: the next generation of the team's fixed 8-bit-command / 32-bit-data SPI slave.
- Adds generic data/address widths, all four SPI modes, burst transfers with address auto-increment, an explicit read-request handshake and frame-error reporting.
- Sits between the off-board SPI master and the register bank. Everything runs in the system `clk` domain; SPI pins are oversampled.

---
 rtl/spi_slave_burst.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_burst.sv
// spi_slave_burst: oversampled SPI slave turning command/data frames into register-bank read and write strobes.
// Latency: cmd_valid, wr_en and rd_req rise 1 clk after the sampling SCLK edge is seen; rd_data is captured 1 clk after rd_req.
// Backpressure: none. The master paces the link, and the register bank must answer every rd_req on the following clk.
//
// Ports: clk/reset_n are the system clock and async active-low reset.
//        SPI_CLK/SPI_CS/SPI_MOSI are asynchronous pins. SPI_MISO/SPI_MISO_OE drive the slave-out pin.
//        rd_req/rd_addr/rd_data form the read handshake. wr_en/wr_addr/wr_data form the write strobe.
//        cmd_valid pulses once per command byte. frame_err is sticky until the next CS falling edge.
// Build option: define SPI_BURST_EN for multi-word bursts with address auto-increment.
//               Without it, one data word per frame is transferred.
module spi_slave_burst #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 4,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              SPI_CLK,
    input  logic              SPI_CS,
    input  logic              SPI_MOSI,
    output logic              SPI_MISO,
    output logic              SPI_MISO_OE,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              cmd_valid,
    output logic              frame_err
);
    localparam int CNT_W = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;
    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] clk_sync, cs_sync, mosi_sync;
    logic                   clk_d;
    logic [CNT_W-1:0]       bit_cnt;
    logic [DATA_W-2:0]      rx;
    logic [DATA_W-1:0]      tx;
    logic [ADDR_W-1:0]      addr;
    logic                   is_wr;
    logic                   load_pend;

    // Synchronisers come out of reset at the bus idle levels.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync  <= {SYNC_STAGES{CPOL}};
            cs_sync   <= '1;
            mosi_sync <= '0;
            clk_d     <= CPOL;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], SPI_CLK};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], SPI_CS};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
            clk_d     <= clk_sync[SYNC_STAGES-1];
        end
    end

    logic sclk_s, cs_s, mosi_s, sclk_rise, sclk_fall, sample_edge, shift_edge;
    logic cmd_last, word_last;
    logic [DATA_W-1:0] rx_nxt;

    assign sclk_s      = clk_sync[SYNC_STAGES-1];
    assign cs_s        = cs_sync[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise   = sclk_s & ~clk_d;
    assign sclk_fall   = ~sclk_s & clk_d;
    // Modes 0 and 3 sample on the rising edge. Modes 1 and 2 sample on the falling edge.
    assign sample_edge = (CPOL == CPHA) ? sclk_rise : sclk_fall;
    assign shift_edge  = (CPOL == CPHA) ? sclk_fall : sclk_rise;
    assign cmd_last    = (bit_cnt == CNT_W'(7));
    assign word_last   = (bit_cnt == CNT_W'(DATA_W - 1));
    // The shift register value including the bit being sampled this clk.
    assign rx_nxt      = {rx, mosi_s};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (!cs_s) state_nxt = CMD;
            CMD: begin
                if (cs_s)                          state_nxt = IDLE;
                else if (sample_edge && cmd_last)  state_nxt = DATA;
            end
            DATA: begin
                if (cs_s) begin
                    state_nxt = IDLE;
                end else begin
`ifdef SPI_BURST_EN
                    state_nxt = DATA;   // a burst runs until CS rises
`else
                    if (sample_edge && word_last) state_nxt = DONE;
`endif
                end
            end
            DONE:    if (cs_s) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt     <= '0;
            rx          <= '0;
            tx          <= '0;
            addr        <= '0;
            is_wr       <= 1'b0;
            load_pend   <= 1'b0;
            SPI_MISO    <= 1'b0;
            SPI_MISO_OE <= 1'b0;
            rd_req      <= 1'b0;
            rd_addr     <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            cmd_valid   <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            wr_en     <= 1'b0;
            rd_req    <= 1'b0;
            // The bank answers rd_req one clk later, so the tx load trails the request by one clk.
            load_pend <= rd_req;
            if (load_pend) tx <= rd_data;

            if (state == IDLE) begin
                bit_cnt   <= '0;
                rx        <= '0;
                tx        <= '0;
                SPI_MISO  <= 1'b0;
                load_pend <= 1'b0;
                if (!cs_s) begin
                    SPI_MISO_OE <= 1'b1;
                    frame_err   <= 1'b0;
                end
            end else if (cs_s) begin
                // CS wins over a coincident sample edge. A partial byte or word is an error and is dropped.
                SPI_MISO    <= 1'b0;
                SPI_MISO_OE <= 1'b0;
                bit_cnt     <= '0;
                if (bit_cnt != '0) frame_err <= 1'b1;
            end else if (state == CMD) begin
                if (sample_edge) begin
                    rx <= rx_nxt[DATA_W-2:0];
                    if (cmd_last) begin
                        bit_cnt   <= '0;
                        cmd_valid <= 1'b1;
                        addr      <= rx_nxt[ADDR_W-1:0];
                        is_wr     <= rx_nxt[7];
                        if (!rx_nxt[7]) begin
                            rd_req  <= 1'b1;
                            rd_addr <= rx_nxt[ADDR_W-1:0];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
            end else if (state == DATA) begin
                if (shift_edge) begin
                    SPI_MISO <= tx[DATA_W-1];
                    tx       <= {tx[DATA_W-2:0], 1'b0};
                end
                if (sample_edge) begin
                    rx <= rx_nxt[DATA_W-2:0];
                    if (word_last) begin
                        bit_cnt <= '0;
                        if (is_wr) begin
                            wr_en   <= 1'b1;
                            wr_addr <= addr;
                            wr_data <= rx_nxt;
                        end
`ifdef SPI_BURST_EN
                        else begin
                            // Prefetch the next word so it is ready by the next shift edge.
                            rd_req  <= 1'b1;
                            rd_addr <= addr + 1'b1;
                        end
                        addr <= addr + 1'b1;
`else
                        SPI_MISO <= 1'b0;
`endif
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
            end else begin
                SPI_MISO <= 1'b0;   // DONE: ignore SCLK until CS rises
            end
        end
    end
endmodule
